cdb_arbiter: RTL
================

# cdb_arbiter

Common-data-bus arbiter that shares the single result-broadcast port between the ALU and the LSU. It sits between the execution units and the result consumers: the re-order buffer, reservation station and load/store buffer. Each requester gets a small per-source FIFO, so a result is never lost when both units finish in the same cycle. Queued results are granted round-robin onto one registered broadcast bus, and everything is flushed on branch rollback.

## Interface
- FIFO_DEPTH, 2, entries per requester queue (power of two, ≥2)
- ROB_ID_W, 5, RoB tag width; tag 0 means "no entry"
- DATA_W, 32, result and target-PC width
- clk_in  in  1  clock; all logic on posedge
- rst_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global ready; low = hold all state
- rollback_in  in  1  RoB misprediction flush
- alu_valid_in  in  1  ALU result present
- alu_rob_id_in  in  ROB_ID_W  ALU result tag
- alu_result_in  in  DATA_W  ALU result
- alu_jump_flag_in  in  1  branch taken
- alu_target_pc_in  in  DATA_W  branch target
- alu_ready_out  out  1  ALU queue can accept
- lsu_valid_in  in  1  LSU result present
- lsu_rob_id_in  in  ROB_ID_W  LSU result tag
- lsu_result_in  in  DATA_W  load data
- lsu_ready_out  out  1  LSU queue can accept
- cdb_valid_out  out  1  broadcast valid
- cdb_rob_id_out  out  ROB_ID_W  broadcast tag
- cdb_result_out  out  DATA_W  broadcast data
- cdb_jump_flag_out  out  1  taken flag (0 for LSU)
- cdb_target_pc_out  out  DATA_W  target (0 for LSU)
- cdb_src_out  out  1  0 = ALU, 1 = LSU

## Operation
- Two FIFOs: ALU queue holds {rob_id, result, jump_flag, target_pc}; LSU queue holds {rob_id, result}.
- Enqueue: a source enqueues when valid_in && ready_out && rob_id_in != 0 && rdy_in && !rollback_in. A tag of 0 is ignored.
- ready_out = (count < FIFO_DEPTH) && rst_in. It depends only on the registered count; a full queue does not accept in the same cycle it dequeues.
- A source that sees ready_out low must hold valid and payload. The block never drops an accepted result.
- Round-robin pointer rr, reset 0 (ALU first). The arbiter looks at non-empty queues each cycle:
  - Both non-empty: grant the queue named by rr; rr then points to the other queue.
  - One non-empty: grant that queue; rr then points to the other queue.
  - Neither: no grant; rr unchanged.
- Granted head is popped. Output registers load its fields; cdb_valid_out = 1.
- No grant: cdb_valid_out = 0. The other outputs keep their last values.
- LSU grants drive jump_flag 0 and target_pc 0.
- Rollback: both FIFOs are emptied, cdb_valid_out = 0 and inputs that cycle are discarded. rr is not changed.
- rdy_in low: no enqueue, no dequeue, outputs and rr held.
- Rollback and reset act regardless of rdy_in; reset has priority over rollback.
- Reset values: cdb_valid_out 0, cdb_rob_id_out 0, cdb_result_out 0, cdb_jump_flag_out 0, cdb_target_pc_out 0, cdb_src_out 0, both counts 0, rr 0.
- Pointer arithmetic: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits. Simultaneous push and pop leaves count unchanged.

## Timing
- Base latency: input accepted at edge N, becomes eligible at N+1, broadcast visible after edge N+1. That is 2 edges from valid to cdb_valid_out.
- Throughput: one broadcast per cycle total.
- Sustained dual traffic alternates ALU, LSU, ALU, …
- cdb_* are registered outputs with no combinational path from any input.
- Rollback asserted at edge N: cdb_valid_out is 0 after edge N. A grant computed in that cycle is cancelled.

## Configuration
- CDB_BYPASS_EN defined: an input arriving at an empty queue whose source would win arbitration goes directly into the output registers at the same edge. It is not enqueued, giving latency 1 edge. Round-robin order is unchanged; bypass only applies when the queue is empty.
- Undefined: every result passes through its FIFO, giving latency 2 edges.

## Structure
- Package cdb_pkg holds:
  - ROB_ID_W, DATA_W
  - typedef cdb_alu_entry_t {rob_id, result, jump_flag, target_pc}
  - typedef cdb_lsu_entry_t {rob_id, result}
  - typedef cdb_src_e {CDB_SRC_ALU = 0, CDB_SRC_LSU = 1}
- One sub-module, cdb_req_fifo: parameterised width and depth, with push/pop/flush, count, full and empty. It is instantiated once per source.

## Test plan
- Single ALU result (tag 3, data 0x1234) after reset, no bypass → cdb_valid_out high 2 edges later with tag 3, 0x1234, src 0, for exactly 1 cycle.
- ALU tag 1 and LSU tag 2 in the same cycle, then ALU tag 4 and LSU tag 5 → broadcasts in order 1, 2, 4, 5 on consecutive cycles.
- LSU presents tags 6, 7, 8 back-to-back with depth 2 and the ALU queue kept busy → lsu_ready_out drops after two accepts; tag 8 is accepted once space frees and no tag is lost or duplicated.
- Queues holding 2 ALU and 1 LSU entries, rollback_in pulsed for 1 cycle → cdb_valid_out 0 next cycle and stays 0; both ready_out signals are 1.
- rdy_in held low for 3 cycles mid-stream → cdb outputs frozen; the sequence resumes unchanged when rdy_in returns high.
- With CDB_BYPASS_EN, ALU tag 9 into an idle arbiter → broadcast after 1 edge.

Source files
------------

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared widths, queue entry layouts and source encoding for the CDB arbiter.
package cdb_pkg;
    localparam int ROB_ID_W = 5;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [DATA_W-1:0]   result;
        logic                jump_flag;
        logic [DATA_W-1:0]   target_pc;
    } cdb_alu_entry_t;

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [DATA_W-1:0]   result;
    } cdb_lsu_entry_t;

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSU = 1'b1
    } cdb_src_e;
endpackage

// File: rtl/cdb_req_fifo.sv
// cdb_req_fifo: per-requester result queue with push/pop/flush and occupancy flags.
module cdb_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;

    always_ff @(posedge clk_in) begin
        if (i_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in || i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_wr <= r_wr + 1'b1;
            if (i_pop)
                r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbitration of queued ALU/LSU results onto one registered CDB.
// Define CDB_BYPASS_EN to let a winning result at an empty queue skip its FIFO.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                rollback_in,
    input  logic                alu_valid_in,
    input  logic [ROB_ID_W-1:0] alu_rob_id_in,
    input  logic [DATA_W-1:0]   alu_result_in,
    input  logic                alu_jump_flag_in,
    input  logic [DATA_W-1:0]   alu_target_pc_in,
    output logic                alu_ready_out,
    input  logic                lsu_valid_in,
    input  logic [ROB_ID_W-1:0] lsu_rob_id_in,
    input  logic [DATA_W-1:0]   lsu_result_in,
    output logic                lsu_ready_out,
    output logic                cdb_valid_out,
    output logic [ROB_ID_W-1:0] cdb_rob_id_out,
    output logic [DATA_W-1:0]   cdb_result_out,
    output logic                cdb_jump_flag_out,
    output logic [DATA_W-1:0]   cdb_target_pc_out,
    output logic                cdb_src_out
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    cdb_alu_entry_t w_alu_in, w_alu_q, w_alu_head;
    cdb_lsu_entry_t w_lsu_in, w_lsu_q, w_lsu_head;
    logic [CW-1:0]  w_alu_count, w_lsu_count;
    logic           w_alu_full, w_alu_empty, w_lsu_full, w_lsu_empty;
    logic           w_go, w_alu_in_ok, w_lsu_in_ok, w_alu_avail, w_lsu_avail;
    logic           w_grant_alu, w_grant_lsu;
    logic           w_alu_push, w_alu_pop, w_lsu_push, w_lsu_pop;

    logic                r_valid;
    logic [ROB_ID_W-1:0] r_rob_id;
    logic [DATA_W-1:0]   r_result;
    logic                r_jump;
    logic [DATA_W-1:0]   r_tpc;
    cdb_src_e            r_src;
    cdb_src_e            r_rr;

    assign w_go          = rdy_in && !rollback_in;
    assign alu_ready_out = rst_in && !w_alu_full;
    assign lsu_ready_out = rst_in && !w_lsu_full;
    assign w_alu_in_ok   = w_go && alu_valid_in && alu_ready_out && alu_rob_id_in != '0;
    assign w_lsu_in_ok   = w_go && lsu_valid_in && lsu_ready_out && lsu_rob_id_in != '0;
    assign w_alu_in      = '{alu_rob_id_in, alu_result_in, alu_jump_flag_in, alu_target_pc_in};
    assign w_lsu_in      = '{lsu_rob_id_in, lsu_result_in};

`ifdef CDB_BYPASS_EN
    assign w_alu_avail = !w_alu_empty || w_alu_in_ok;
    assign w_lsu_avail = !w_lsu_empty || w_lsu_in_ok;
`else
    assign w_alu_avail = !w_alu_empty;
    assign w_lsu_avail = !w_lsu_empty;
`endif

    assign w_grant_alu = w_alu_avail && (!w_lsu_avail || r_rr == CDB_SRC_ALU);
    assign w_grant_lsu = w_lsu_avail && !w_grant_alu;
    // A granted source with an empty queue can only be a bypassed input.
    assign w_alu_head  = w_alu_empty ? w_alu_in : w_alu_q;
    assign w_lsu_head  = w_lsu_empty ? w_lsu_in : w_lsu_q;
    assign w_alu_pop   = w_go && w_grant_alu && !w_alu_empty;
    assign w_lsu_pop   = w_go && w_grant_lsu && !w_lsu_empty;
    assign w_alu_push  = w_alu_in_ok && !(w_grant_alu && w_alu_empty);
    assign w_lsu_push  = w_lsu_in_ok && !(w_grant_lsu && w_lsu_empty);

    cdb_req_fifo #(.WIDTH($bits(cdb_alu_entry_t)), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_alu_push),
        .i_pop   (w_alu_pop),
        .i_flush (rollback_in),
        .i_data  (w_alu_in),
        .o_data  (w_alu_q),
        .o_count (w_alu_count),
        .o_full  (w_alu_full),
        .o_empty (w_alu_empty)
    );

    cdb_req_fifo #(.WIDTH($bits(cdb_lsu_entry_t)), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_lsu_push),
        .i_pop   (w_lsu_pop),
        .i_flush (rollback_in),
        .i_data  (w_lsu_in),
        .o_data  (w_lsu_q),
        .o_count (w_lsu_count),
        .o_full  (w_lsu_full),
        .o_empty (w_lsu_empty)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in)
            assert (w_alu_count <= CW'(FIFO_DEPTH) && w_lsu_count <= CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_valid  <= 1'b0;
            r_rob_id <= '0;
            r_result <= '0;
            r_jump   <= 1'b0;
            r_tpc    <= '0;
            r_src    <= CDB_SRC_ALU;
            r_rr     <= CDB_SRC_ALU;
        end else if (rollback_in) begin
            r_valid <= 1'b0;
        end else if (rdy_in) begin
            r_valid <= w_grant_alu || w_grant_lsu;
            if (w_grant_alu) begin
                r_rob_id <= w_alu_head.rob_id;
                r_result <= w_alu_head.result;
                r_jump   <= w_alu_head.jump_flag;
                r_tpc    <= w_alu_head.target_pc;
                r_src    <= CDB_SRC_ALU;
                r_rr     <= CDB_SRC_LSU;
            end else if (w_grant_lsu) begin
                r_rob_id <= w_lsu_head.rob_id;
                r_result <= w_lsu_head.result;
                r_jump   <= 1'b0;
                r_tpc    <= '0;
                r_src    <= CDB_SRC_LSU;
                r_rr     <= CDB_SRC_ALU;
            end
        end
    end

    assign cdb_valid_out     = r_valid;
    assign cdb_rob_id_out    = r_rob_id;
    assign cdb_result_out    = r_result;
    assign cdb_jump_flag_out = r_jump;
    assign cdb_target_pc_out = r_tpc;
    assign cdb_src_out       = r_src;
endmodule
